// File: rtl/seq_alu_if.sv
// Operand/result bus between the control unit and the sequential ALU.
// The master drives the request, and the slave (the ALU) returns results and status.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] Rb;
    logic [WIDTH-1:0] Ry;
    logic [WIDTH-1:0] resultLo;
    logic [WIDTH-1:0] resultHi;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, Rb, Ry,
        input  resultLo, resultHi, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, Rb, Ry,
        output resultLo, resultHi, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, radix-2 Booth MUL and
// restoring DIV, with a double-width HI/LO result and start/busy/done sequencing.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clock,
    input  logic       clear_n,
    seq_alu_if.slave   bus
);
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NEG  = 4'd2;
    localparam logic [3:0] OP_NOT  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SHRA = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    typedef enum logic [2:0] {IDLE, MUL_IT, DIV_IT, DIV_FIX, FINISH} state_t;

    state_t           state_reg;
    logic             go_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [WIDTH:0]   acc_reg;
    logic [WIDTH-1:0] q_reg;
    logic             qm1_reg;
    logic [WIDTH-1:0] m_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] hi_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dbz_reg;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    // A captured MUL/DIV blocks new requests until the FSM has moved into iteration.
    logic multi_pending;
    logic accept;
    assign multi_pending = (op_reg == OP_MUL) || ((op_reg == OP_DIV) && (b_reg != '0));
    assign accept = bus.start && ((state_reg == IDLE) || (state_reg == FINISH))
                    && !(go_reg && multi_pending);

    // Single-cycle datapath; rotates use a doubled operand so ROL is ROR by -amt.
    logic [SHW-1:0]     amt;
    logic [SHW-1:0]     rol_amt;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   single_lo;
    logic [WIDTH-1:0]   single_hi;
    logic               single_dbz;

    assign amt     = b_reg[SHW-1:0];
    assign rol_amt = -amt;
    assign dbl     = {a_reg, a_reg};

    always_comb begin
        single_lo  = '0;
        single_hi  = '0;
        single_dbz = 1'b0;
        case (op_reg)
            OP_AND:  single_lo = a_reg & b_reg;
            OP_OR:   single_lo = a_reg | b_reg;
            OP_NEG:  single_lo = -b_reg;
            OP_NOT:  single_lo = ~b_reg;
            OP_ADD:  single_lo = a_reg + b_reg;
            OP_SUB:  single_lo = a_reg - b_reg;
            OP_SHR:  single_lo = a_reg >> amt;
            OP_SHRA: single_lo = $signed(a_reg) >>> amt;
            OP_SHL:  single_lo = a_reg << amt;
            OP_ROR:  single_lo = WIDTH'(dbl >> amt);
            OP_ROL:  single_lo = WIDTH'(dbl >> rol_amt);
            OP_DIV: begin
                single_hi  = a_reg;
                single_dbz = 1'b1;
            end
            default: single_lo = '0;
        endcase
    end

    // Booth step: acc carries one guard bit so subtracting the most negative
    // multiplicand cannot overflow.
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_acc_next;
    logic [WIDTH-1:0] booth_q_next;

    assign m_ext = {m_reg[WIDTH-1], m_reg};

    always_comb begin
        booth_sum = acc_reg;
        case ({q_reg[0], qm1_reg})
            2'b01:   booth_sum = acc_reg + m_ext;
            2'b10:   booth_sum = acc_reg - m_ext;
            default: booth_sum = acc_reg;
        endcase
    end

    assign booth_acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    assign booth_q_next   = {booth_sum[0], q_reg[WIDTH-1:1]};

    // Restoring division step on magnitudes; the diff sign bit decides restore.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH:0]   div_acc_next;
    logic [WIDTH-1:0] div_q_next;

    assign div_shift    = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign div_diff     = div_shift - {1'b0, m_reg};
    assign div_ok       = ~div_diff[WIDTH];
    assign div_acc_next = div_ok ? div_diff : div_shift;
    assign div_q_next   = {q_reg[WIDTH-2:0], div_ok};

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg <= IDLE;
            go_reg    <= 1'b0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            q_reg     <= '0;
            qm1_reg   <= 1'b0;
            m_reg     <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            lo_reg    <= '0;
            hi_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
        end else begin
            if (accept) begin
                go_reg <= 1'b1;
                op_reg <= bus.op;
                a_reg  <= bus.Rb;
                b_reg  <= bus.Ry;
            end else begin
                go_reg <= 1'b0;
            end

            case (state_reg)
                IDLE, FINISH: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                    if (go_reg) begin
                        if (op_reg == OP_MUL) begin
                            acc_reg   <= '0;
                            q_reg     <= b_reg;
                            qm1_reg   <= 1'b0;
                            m_reg     <= a_reg;
                            cnt_reg   <= '0;
                            busy_reg  <= 1'b1;
                            state_reg <= MUL_IT;
                        end else if ((op_reg == OP_DIV) && (b_reg != '0)) begin
                            acc_reg   <= '0;
                            q_reg     <= mag(a_reg);
                            m_reg     <= mag(b_reg);
                            neg_q_reg <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
                            neg_r_reg <= a_reg[WIDTH-1];
                            cnt_reg   <= '0;
                            busy_reg  <= 1'b1;
                            state_reg <= DIV_IT;
                        end else begin
                            lo_reg   <= single_lo;
                            hi_reg   <= single_hi;
                            dbz_reg  <= single_dbz;
                            done_reg <= 1'b1;
                        end
                    end
                end
                MUL_IT: begin
                    acc_reg <= booth_acc_next;
                    q_reg   <= booth_q_next;
                    qm1_reg <= q_reg[0];
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == SHW'(WIDTH - 1)) begin
                        lo_reg    <= booth_q_next;
                        hi_reg    <= booth_acc_next[WIDTH-1:0];
                        dbz_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= FINISH;
                    end
                end
                DIV_IT: begin
                    acc_reg <= div_acc_next;
                    q_reg   <= div_q_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == SHW'(WIDTH - 1)) begin
                        state_reg <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    lo_reg    <= neg_q_reg ? -q_reg : q_reg;
                    hi_reg    <= neg_r_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
                    dbz_reg   <= 1'b0;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= FINISH;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.resultLo    = lo_reg;
    assign bus.resultHi    = hi_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized requests
// compared against a plain-arithmetic reference model, including timing.
module tb_seq_alu;
    logic clk;
    logic clear_n;
    int   n_tests;
    int   n_fail;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clock   (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: results from signed/unsigned arithmetic, latency in edges after the sampling edge.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic dbz, output int lat);
        int unsigned n;
        longint      p;
        longint      sa;
        longint      sb;
        longint      qq;
        longint      rr;
        n   = b[4:0];
        lo  = '0;
        hi  = '0;
        dbz = 1'b0;
        lat = 1;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (op)
            4'd0:  lo = a & b;
            4'd1:  lo = a | b;
            4'd2:  lo = -b;
            4'd3:  lo = ~b;
            4'd4:  lo = a + b;
            4'd5:  lo = a - b;
            4'd6:  lo = a >> n;
            4'd7:  lo = $signed(a) >>> n;
            4'd8:  lo = a << n;
            4'd9:  lo = (a >> n) | (a << ((32 - n) % 32));
            4'd10: lo = (a << n) | (a >> ((32 - n) % 32));
            4'd11: begin
                p   = sa * sb;
                lo  = p[31:0];
                hi  = p[63:32];
                lat = 33;
            end
            4'd12: begin
                if (b == 32'd0) begin
                    hi  = a;
                    dbz = 1'b1;
                end else begin
                    qq  = sa / sb;
                    rr  = sa % sb;
                    lo  = qq[31:0];
                    hi  = rr[31:0];
                    lat = 34;
                end
            end
            default: lo = '0;
        endcase
    endfunction

    // Caller must be at a negedge. Returns at the negedge where done is seen
    // (b2b=1) or one cycle later after confirming done dropped (b2b=0).
    task automatic run_op(input logic [3:0] op_i, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, input bit b2b, input string tag);
        logic [31:0] e_lo;
        logic [31:0] e_hi;
        logic        e_dbz;
        int          lat;
        int          k;
        bit          seen;
        bit          seq_ok;
        logic [31:0] g_lo;
        logic [31:0] g_hi;
        logic        g_dbz;
        model(op_i, a, b, e_lo, e_hi, e_dbz, lat);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.Rb    = a;
        bus.Ry    = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 4'($urandom);
        bus.Rb    = $urandom;
        bus.Ry    = $urandom;
        seen   = 1'b0;
        seq_ok = 1'b1;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.busy !== ((k >= 1) && (k < lat))) seq_ok = 1'b0;
            if (poke) begin
                bus.start = (k == 9);
                bus.op    = 4'd4;
            end
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        g_lo  = bus.resultLo;
        g_hi  = bus.resultHi;
        g_dbz = bus.div_by_zero;
        check({tag, ".latency"}, 64'(k), 64'(lat));
        check({tag, ".lo"}, g_lo, e_lo);
        check({tag, ".hi"}, g_hi, e_hi);
        check({tag, ".dbz"}, g_dbz, e_dbz);
        check({tag, ".busy_seq"}, seq_ok, 1'b1);
        $display("[TB] %s op=%0d a=%h b=%h lo=%h hi=%h dbz=%b edges=%0d seen=%0d",
                 tag, op_i, a, b, g_lo, g_hi, g_dbz, k, seen);
        if (!b2b) begin
            @(negedge clk);
            check({tag, ".done_pulse"}, bus.done, 1'b0);
        end
    endtask

    initial begin
        bit          no_done;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_tests   = 0;
        n_fail    = 0;
        clear_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.Rb    = '0;
        bus.Ry    = '0;
        #12;
        check("reset.lo", bus.resultLo, 32'h0);
        check("reset.hi", bus.resultHi, 32'h0);
        check("reset.busy", bus.busy, 1'b0);
        check("reset.done", bus.done, 1'b0);
        check("reset.dbz", bus.div_by_zero, 1'b0);
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);

        run_op(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0, "and");
        run_op(4'd2, 32'h1234_5678, 32'h0000_0005, 1'b0, 1'b0, "neg");
        run_op(4'd7, 32'h8000_0000, 32'h0000_0004, 1'b0, 1'b0, "shra");
        run_op(4'd10, 32'h8000_0001, 32'h0000_0021, 1'b0, 1'b0, "rol");
        run_op(4'd9, 32'h8000_0001, 32'h0000_0000, 1'b0, 1'b0, "ror0");
        run_op(4'd11, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 1'b0, "mul_neg3x7");
        run_op(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "mul_min_poke");
        run_op(4'd12, 32'hFFFF_FFEF, 32'h0000_0005, 1'b0, 1'b0, "div_m17_5");
        run_op(4'd12, 32'h0000_0009, 32'h0000_0000, 1'b0, 1'b0, "div_zero");
        run_op(4'd14, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, "reserved");
        run_op(4'd11, 32'h0000_1234, 32'hFFFF_0001, 1'b0, 1'b1, "mul_b2b");
        run_op(4'd1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, "or_b2b");

        // Leave nonzero results, then abort a MUL mid-flight with clear_n.
        run_op(4'd12, 32'h0000_0064, 32'h0000_0007, 1'b0, 1'b0, "div_pre_reset");
        bus.start = 1'b1;
        bus.op    = 4'd11;
        bus.Rb    = 32'h0000_0005;
        bus.Ry    = 32'h0000_0006;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("abort.busy_before", bus.busy, 1'b1);
        clear_n = 1'b0;
        #1;
        check("abort.lo", bus.resultLo, 32'h0);
        check("abort.hi", bus.resultHi, 32'h0);
        check("abort.busy", bus.busy, 1'b0);
        check("abort.done", bus.done, 1'b0);
        check("abort.dbz", bus.div_by_zero, 1'b0);
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        no_done = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
        end
        check("abort.no_done", no_done, 1'b1);
        run_op(4'd4, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, "add_after_reset");

        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(0, 40));
                3: if (rop == 4'd12) rb = 32'h0;
                default: ;
            endcase
            run_op(rop, ra, rb, 1'b0, ($urandom_range(0, 3) == 0), $sformatf("rand%0d", i));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
